// File: rtl/req_ack_arbiter_if.sv
// ----------------------------------------------------------------------------
// req_ack_arbiter_if
//   Handshake/data bundle between the requesting masters, the resource
//   qualifiers and the req_ack_arbiter.
//
//   Signals:
//     ready, go   resource qualifiers (resource -> arbiter)
//     pri_mode    0 = fixed priority (req[1] highest), 1 = round robin
//     req[1:0]    per-master request, held high until the master is done
//     data0/data1 per-master data words
//     ack[1:0]    one-hot grant (arbiter -> masters)
//     data_out    winner's data word, captured at grant
//     data_vld    one-cycle pulse in the first grant cycle
//     busy        arbiter is not idle
//     err_to      one-cycle pulse on a watchdog release
//
//   Modports:
//     master  requester/resource side: drives requests and qualifiers
//     slave   arbiter side: drives grant, data and status
// ----------------------------------------------------------------------------
interface req_ack_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic          ready;
    logic          go;
    logic          pri_mode;
    logic [1:0]    req;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic [1:0]    ack;
    logic [DW-1:0] data_out;
    logic          data_vld;
    logic          busy;
    logic          err_to;

    modport master (
        output ready, go, pri_mode, req, data0, data1,
        input  ack, data_out, data_vld, busy, err_to
    );

    modport slave (
        input  ready, go, pri_mode, req, data0, data1,
        output ack, data_out, data_vld, busy, err_to
    );
endinterface

// File: rtl/req_ack_arbiter.sv
// ----------------------------------------------------------------------------
// req_ack_arbiter
//   Shares one downstream resource between two masters using a four-phase
//   req/ack handshake. Arbitration is qualified by the resource's ready and
//   go inputs; the winner is chosen by fixed (master 1 highest) or
//   round-robin priority. The winner's data word is captured at grant and
//   the grant is held until the winner drops its request, the resource
//   drops ready, or the grant-hold watchdog expires.
//
//   Parameters:
//     DW       data word width
//     TIMEOUT  max consecutive grant cycles before a forced release (2..255)
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous, active-high reset
//     bus      req_ack_arbiter_if slave modport (see interface for signals)
// ----------------------------------------------------------------------------
module req_ack_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    req_ack_arbiter_if.slave   bus
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [1:0]    ack_q,      ack_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          data_vld_q, data_vld_d;
    logic          err_to_q,   err_to_d;
    logic          last_win_q, last_win_d;
    logic          win_q,      win_d;      // index of the current grant holder
    logic [7:0]    cnt_q,      cnt_d;      // cycles the current grant has lasted

    logic          arb_ok;
    logic          arb_win;
    logic          req_w;

    // Arbitration qualifier and winner selection (combinational, used only
    // on the arbitration edge, so pri_mode matters only there).
    always_comb begin
        arb_ok  = bus.ready && bus.go && (|bus.req);
        arb_win = 1'b0;
        unique case (bus.req)
            2'b01:   arb_win = 1'b0;
            2'b10:   arb_win = 1'b1;
            2'b11:   arb_win = bus.pri_mode ? ~last_win_q : 1'b1;
            default: arb_win = 1'b0;
        endcase
    end

    // Request bit of the master currently holding (or last holding) the grant.
    assign req_w = bus.req[win_q];

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        data_out_d = data_out_q;
        data_vld_d = 1'b0;
        err_to_d   = 1'b0;
        last_win_d = last_win_q;
        win_d      = win_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            IDLE: begin
                ack_d = 2'b00;
                if (arb_ok) begin
                    win_d          = arb_win;
                    ack_d          = 2'b00;
                    ack_d[arb_win] = 1'b1;
                    data_out_d     = arb_win ? bus.data1 : bus.data0;
                    data_vld_d     = 1'b1;
                    cnt_d          = 8'd1;
                    state_d        = GRANT;
                end
            end

            GRANT: begin
                // Ordered checks give release > ready loss > watchdog.
                if (!req_w) begin
                    ack_d      = 2'b00;
                    last_win_d = win_q;
                    state_d    = IDLE;
                end else if (!bus.ready) begin
                    ack_d   = 2'b00;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    ack_d      = 2'b00;
                    err_to_d   = 1'b1;
                    last_win_d = win_q;
                    state_d    = HOLDOFF;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            HOLDOFF: begin
                ack_d = 2'b00;
                if (!req_w) begin
                    state_d = IDLE;
                end
            end

            default: begin
                ack_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            err_to_q   <= 1'b0;
            last_win_q <= 1'b1;
            win_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            data_out_q <= data_out_d;
            data_vld_q <= data_vld_d;
            err_to_q   <= err_to_d;
            last_win_q <= last_win_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.data_out = data_out_q;
    assign bus.data_vld = data_vld_q;
    assign bus.err_to   = err_to_q;
    assign bus.busy     = (state_q != IDLE);

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));
    a_vld_has_ack: assert property (@(posedge clk) disable iff (rst) data_vld_q |-> (ack_q != 2'b00));
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
module tb_req_ack_arbiter;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] D0A = 32'hA0A0_0001;
    localparam logic [DW-1:0] D0B = 32'hA0A0_00FF;
    localparam logic [DW-1:0] D1A = 32'hB1B1_0002;

    typedef struct {
        logic [1:0]    ack;
        logic          vld;
        logic          err;
        logic          busy;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    exp_t sb[$];

    req_ack_arbiter_if #(.DW(DW)) bus ();

    req_ack_arbiter #(.DW(DW), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, want finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.ready = 1'b0; bus.go = 1'b0; bus.pri_mode = 1'b0;
        bus.req = 2'b00; bus.data0 = D0A; bus.data1 = D1A;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.ack !== 2'b00) begin fails++; $display("FAIL reset.ack got %b want 00", bus.ack); end
        tests++; if (bus.data_out !== '0) begin fails++; $display("FAIL reset.data_out got %h want 0", bus.data_out); end
        tests++; if (bus.data_vld !== 1'b0) begin fails++; $display("FAIL reset.data_vld got %b want 0", bus.data_vld); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset.busy got %b want 0", bus.busy); end
        tests++; if (bus.err_to !== 1'b0) begin fails++; $display("FAIL reset.err_to got %b want 0", bus.err_to); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] rq [0:4];
        logic [1:0] ea [0:4];
        logic       ev [0:4];
        exp_t e;
        rq = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        ea = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        ev = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.ready = 1'b1; bus.go = 1'b1; bus.pri_mode = 1'b0; bus.data0 = D0A;
        for (int i = 0; i < 5; i++) begin
            bus.req = rq[i];
            e.ack = ea[i]; e.vld = ev[i]; e.err = 1'b0; e.busy = (ea[i] != 2'b00); e.data = D0A;
            sb.push_back(e);
            @(posedge clk); #1;
            // data0 changes mid-grant; captured value must hold
            if (i == 1) bus.data0 = D0B;
            e = sb.pop_front();
            tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL single.ack[%0d] got %b want %b", i, bus.ack, e.ack); end
            tests++; if (bus.data_vld !== e.vld) begin fails++; $display("FAIL single.vld[%0d] got %b want %b", i, bus.data_vld, e.vld); end
            tests++; if (bus.data_out !== e.data) begin fails++; $display("FAIL single.data[%0d] got %h want %h", i, bus.data_out, e.data); end
            tests++; if (bus.busy !== e.busy) begin fails++; $display("FAIL single.busy[%0d] got %b want %b", i, bus.busy, e.busy); end
        end
    endtask

    task automatic test_fixed();
        logic [1:0] rq [0:8];
        logic [1:0] ea [0:8];
        exp_t e;
        rq = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
        ea = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        bus.ready = 1'b1; bus.go = 1'b1; bus.pri_mode = 1'b0;
        bus.data0 = D0A; bus.data1 = D1A;
        for (int i = 0; i < 9; i++) begin
            bus.req = rq[i];
            e.ack = ea[i]; e.vld = 1'b0; e.err = 1'b0; e.busy = (ea[i] != 2'b00);
            e.data = (ea[i] == 2'b01) ? D0A : D1A;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL fixed.ack[%0d] got %b want %b", i, bus.ack, e.ack); end
            if (e.ack != 2'b00) begin
                tests++; if (bus.data_out !== e.data) begin fails++; $display("FAIL fixed.data[%0d] got %h want %h", i, bus.data_out, e.data); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] rq [0:8];
        logic [1:0] ea [0:8];
        exp_t e;
        rq = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00};
        ea = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        bus.req = 2'b00; bus.pri_mode = 1'b1; bus.ready = 1'b1; bus.go = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.req = rq[i];
            e.ack = ea[i]; e.vld = (ea[i] != 2'b00); e.err = 1'b0; e.busy = (ea[i] != 2'b00); e.data = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL rr.ack[%0d] got %b want %b", i, bus.ack, e.ack); end
            tests++; if (bus.data_vld !== e.vld) begin fails++; $display("FAIL rr.vld[%0d] got %b want %b", i, bus.data_vld, e.vld); end
        end
    endtask

    task automatic test_gating();
        logic [1:0] rq [0:8];
        logic       rd [0:8];
        logic       gg [0:8];
        logic [1:0] ea [0:8];
        exp_t e;
        rq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        rd = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        gg = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
        ea = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        bus.pri_mode = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.req = rq[i]; bus.ready = rd[i]; bus.go = gg[i];
            e.ack = ea[i]; e.vld = 1'b0; e.err = 1'b0; e.busy = (ea[i] != 2'b00); e.data = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL gating.ack[%0d] got %b want %b", i, bus.ack, e.ack); end
            tests++; if (bus.err_to !== e.err) begin fails++; $display("FAIL gating.err_to[%0d] got %b want %b", i, bus.err_to, e.err); end
            tests++; if (bus.busy !== e.busy) begin fails++; $display("FAIL gating.busy[%0d] got %b want %b", i, bus.busy, e.busy); end
        end
        bus.ready = 1'b1; bus.go = 1'b1;
    endtask

    task automatic test_watchdog();
        logic [1:0] rq [0:13];
        logic [1:0] ea [0:13];
        logic       ee [0:13];
        logic       eb [0:13];
        exp_t e;
        rq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11,
               2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        ea = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
               2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.ready = 1'b1; bus.go = 1'b1; bus.pri_mode = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.req = rq[i];
            e.ack = ea[i]; e.vld = 1'b0; e.err = ee[i]; e.busy = eb[i]; e.data = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL wdog.ack[%0d] got %b want %b", i, bus.ack, e.ack); end
            tests++; if (bus.err_to !== e.err) begin fails++; $display("FAIL wdog.err_to[%0d] got %b want %b", i, bus.err_to, e.err); end
            tests++; if (bus.busy !== e.busy) begin fails++; $display("FAIL wdog.busy[%0d] got %b want %b", i, bus.busy, e.busy); end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        bus.ready = 1'b1; bus.go = 1'b1; bus.pri_mode = 1'b1;
        bus.data0 = D0A; bus.data1 = D1A;
        bus.req = 2'b10;
        e.ack = 2'b10; e.vld = 1'b1; e.err = 1'b0; e.busy = 1'b1; e.data = D1A;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL areset.pre_ack got %b want %b", bus.ack, e.ack); end
        tests++; if (bus.data_out !== e.data) begin fails++; $display("FAIL areset.pre_data got %h want %h", bus.data_out, e.data); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.ack !== 2'b00) begin fails++; $display("FAIL areset.ack got %b want 00", bus.ack); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL areset.busy got %b want 0", bus.busy); end
        tests++; if (bus.data_vld !== 1'b0) begin fails++; $display("FAIL areset.vld got %b want 0", bus.data_vld); end
        tests++; if (bus.data_out !== '0) begin fails++; $display("FAIL areset.data got %h want 0", bus.data_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 2'b11;
        e.ack = 2'b01; e.vld = 1'b1; e.err = 1'b0; e.busy = 1'b1; e.data = D0A;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL areset.post_ack got %b want %b", bus.ack, e.ack); end
        tests++; if (bus.data_out !== e.data) begin fails++; $display("FAIL areset.post_data got %h want %h", bus.data_out, e.data); end
        bus.req = 2'b00;
        e.ack = 2'b00; e.vld = 1'b0; e.err = 1'b0; e.busy = 1'b0; e.data = D0A;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        tests++; if (bus.ack !== e.ack) begin fails++; $display("FAIL areset.release_ack got %b want %b", bus.ack, e.ack); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_fixed();
        test_round_robin();
        test_gating();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
